// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU scheduler.
//   opcode_e      - ALU operation encoding (ADD=0, SUB=1, MUL=2, XOR=3)
//   sched_state_e - scheduler FSM states (IDLE, EXEC, RESP)
//   ALU_RES_W     - width of the ALU result
package alu_pkg;

  localparam int ALU_RES_W = 16;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    XOR = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

endpackage

// File: rtl/alu_sched_alu.sv
// alu_datapath: 8-bit operands, 16-bit result, zero-extended arithmetic.
//   a, b in  8          operands
//   op   in  opcode_e   operation
//   res  out ALU_RES_W  result; unknown encodings give 0
module alu_datapath
  import alu_pkg::*;
(
  input  logic [7:0]           a,
  input  logic [7:0]           b,
  input  opcode_e              op,
  output logic [ALU_RES_W-1:0] res
);

  logic [ALU_RES_W-1:0] ax, bx;

  assign ax = {8'h00, a};
  assign bx = {8'h00, b};

  always_comb begin
    res = '0;
    case (op)
      ADD:     res = ax + bx;
      SUB:     res = ax - bx;   // wraps modulo 2^16
      MUL:     res = ax * bx;
      XOR:     res = ax ^ bx;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req     in  N   request vector
//   ptr     in  IW  highest-priority index; search goes upward and wraps
//   en      in  1   gate; no grant when low
//   gnt     out N   one-hot grant
//   gnt_idx out IW  index of the granted bit (0 when no grant)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int k;

  // Walk offsets from farthest to nearest; the nearest hit overwrites the
  // others, so the first requester at or above ptr wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    k       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      if (en && req[k]) begin
        gnt     = '0;
        gnt[k]  = 1'b1;
        gnt_idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one ALU between NUM_REQ clients.
//   clk, rst            clock, async active-high reset
//   req_valid/req_ready per-requester handshake (ready is combinational)
//   req_a, req_b, req_op per-requester operands and opcode
//   rsp_valid/rsp_ready response handshake
//   rsp_id, rsp_result  owner index and 16-bit result (registered)
//   busy                high whenever the FSM is not IDLE
//   stat_cnt            per-requester saturating accept counters, present
//                       only when ALU_SCHED_STATS_EN is defined
// One operation takes IDLE(accept) -> EXEC -> RESP, i.e. 3 cycles minimum.
module alu_sched
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][7:0]       req_a,
  input  logic [NUM_REQ-1:0][7:0]       req_b,
  input  opcode_e [NUM_REQ-1:0]         req_op,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [ALU_RES_W-1:0]          rsp_result,
`ifdef ALU_SCHED_STATS_EN
  output logic [NUM_REQ-1:0][15:0]      stat_cnt,
`endif
  output logic                          busy
);

  sched_state_e         state;
  logic [ID_W-1:0]      ptr, cur_id, gnt_idx, ptr_nxt;
  logic [NUM_REQ-1:0]   gnt;
  logic [7:0]           a_q, b_q;
  opcode_e              op_q;
  logic [ALU_RES_W-1:0] alu_res;
  logic                 accept;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (state == IDLE),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  alu_datapath alu (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .res (alu_res)
  );

  // Grant is already qualified by req_valid, so any grant is an accept.
  assign req_ready = gnt;
  assign accept    = |gnt;
  assign busy      = (state != IDLE);
  assign ptr_nxt   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cur_id     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= ADD;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q    <= req_a[gnt_idx];
          b_q    <= req_b[gnt_idx];
          op_q   <= req_op[gnt_idx];
          cur_id <= gnt_idx;
          ptr    <= ptr_nxt;
          state  <= EXEC;
        end
        EXEC: begin
          rsp_result <= alu_res;
          rsp_id     <= cur_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        // rsp_valid is already high here, so a ready seen during EXEC
        // never completes the handshake early.
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SCHED_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        stat_cnt[i] <= '0;
      else if (gnt[i] && stat_cnt[i] != 16'hFFFF)
        stat_cnt[i] <= stat_cnt[i] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: scenario tasks plus a randomized run checked against a
// round-robin/arithmetic reference model.
module tb_alu_sched;
  import alu_pkg::*;

  localparam int NR = 4;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NR-1:0]        req_valid, req_ready;
  logic [NR-1:0][7:0]   req_a, req_b;
  opcode_e [NR-1:0]     req_op;
  logic                 rsp_valid, rsp_ready;
  logic [IW-1:0]        rsp_id;
  logic [15:0]          rsp_result;
  logic                 busy;
`ifdef ALU_SCHED_STATS_EN
  logic [NR-1:0][15:0]  stat_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int ptr_m     = 0;

  always #5 clk = ~clk;

  alu_sched #(.NUM_REQ(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
`ifdef ALU_SCHED_STATS_EN
    .stat_cnt   (stat_cnt),
`endif
    .busy       (busy)
  );

  function automatic logic [15:0] ref_alu(int a, int b, int op);
    case (op)
      0:       return 16'(a + b);
      1:       return 16'((a - b + 65536) % 65536);
      2:       return 16'(a * b);
      3:       return 16'(a ^ b);
      default: return 16'h0;
    endcase
  endfunction

  function automatic int ref_pick(logic [NR-1:0] v, int p);
    for (int i = 0; i < NR; i++)
      if (v[(p + i) % NR]) return (p + i) % NR;
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    tick();
    rst = 1'b0;
    ptr_m = 0;
  endtask

  // Accept from 'mask' with rsp_ready=1; reports ready at accept time and
  // the response seen in RESP.
  task automatic run_txn(input logic [NR-1:0] mask, output logic [NR-1:0] rdy,
                         output logic [IW-1:0] id, output logic [15:0] res);
    req_valid = mask; rsp_ready = 1'b1;
    #1 rdy = req_ready;
    tick();
    req_valid = '0;
    tick();
    id = rsp_id; res = rsp_result;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = {NR{ADD}};
    tick(); tick();
    total_cnt++; if (req_ready !== 4'b0) $display("FAIL reset_req_ready got %b want 0", req_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id got %0d want 0", rsp_id); else pass_cnt++;
    total_cnt++; if (rsp_result !== 16'h0) $display("FAIL reset_rsp_result got %h want 0", rsp_result); else pass_cnt++;
    rst = 1'b0;
    ptr_m = 0;
  endtask

  task automatic test_add;
    req_a[0] = 8'd200; req_b[0] = 8'd100; req_op[0] = ADD;
    req_valid = 4'b0001; rsp_ready = 1'b1;
    #1;
    total_cnt++; if (req_ready !== 4'b0001) $display("FAIL add_ready got %b want 0001", req_ready); else pass_cnt++;
    tick();
    req_valid = '0;
    total_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b1) $display("FAIL add_exec got v=%b busy=%b want v=0 busy=1", rsp_valid, busy); else pass_cnt++;
    tick();
    total_cnt++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 16'd300)
      $display("FAIL add_rsp got v=%b id=%0d res=%0d want v=1 id=0 res=300", rsp_valid, rsp_id, rsp_result); else pass_cnt++;
    tick();
    total_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL add_done got v=%b busy=%b want 0 0", rsp_valid, busy); else pass_cnt++;
    ptr_m = 1;
  endtask

  task automatic test_round_robin;
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req_a[0] = 8'd7;    req_b[0] = 8'd9;    req_op[0] = ADD;
    req_a[1] = 8'd5;    req_b[1] = 8'd10;   req_op[1] = SUB;
    req_a[2] = 8'd255;  req_b[2] = 8'd255;  req_op[2] = MUL;
    req_a[3] = 8'hF0;   req_b[3] = 8'h3C;   req_op[3] = XOR;
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      int g;
      logic [15:0] exp;
      g = order[n];
      exp = ref_alu(int'(req_a[g]), int'(req_b[g]), int'(req_op[g]));
      #1;
      total_cnt++; if (req_ready !== NR'(1 << g)) $display("FAIL rr_grant%0d got %b want %b", n, req_ready, NR'(1 << g)); else pass_cnt++;
      tick(); tick();
      total_cnt++; if (rsp_valid !== 1'b1 || rsp_id !== IW'(g) || rsp_result !== exp)
        $display("FAIL rr_rsp%0d got v=%b id=%0d res=%h want id=%0d res=%h", n, rsp_valid, rsp_id, rsp_result, g, exp); else pass_cnt++;
      total_cnt++; if (req_ready !== 4'b0) $display("FAIL rr_resp_ready%0d got %b want 0", n, req_ready); else pass_cnt++;
      tick();
    end
    req_valid = '0;
    ptr_m = 1;
  endtask

  task automatic test_backpressure;
    logic [IW-1:0] id0;
    logic [15:0]   res0;
    req_a[2] = 8'd5; req_b[2] = 8'd10; req_op[2] = SUB;
    req_valid = 4'b0100; rsp_ready = 1'b0;
    tick();                      // accept req2
    req_valid = 4'b1111;
    rsp_ready = 1'b1;            // ready during EXEC must not complete anything
    tick();
    rsp_ready = 1'b0;
    id0 = rsp_id; res0 = rsp_result;
    total_cnt++; if (rsp_valid !== 1'b1 || id0 !== 2'd2 || res0 !== 16'hFFFB)
      $display("FAIL bp_rsp got v=%b id=%0d res=%h want v=1 id=2 res=fffb", rsp_valid, id0, res0); else pass_cnt++;
    for (int c = 0; c < 10; c++) begin
      tick();
      total_cnt++; if (rsp_valid !== 1'b1 || rsp_id !== id0 || rsp_result !== res0 || req_ready !== 4'b0 || busy !== 1'b1)
        $display("FAIL bp_hold%0d got v=%b id=%0d res=%h rdy=%b busy=%b want held", c, rsp_valid, rsp_id, rsp_result, req_ready, busy);
      else pass_cnt++;
    end
    req_valid = '0; rsp_ready = 1'b1;
    tick();
    total_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_release got v=%b busy=%b want 0 0", rsp_valid, busy); else pass_cnt++;
    ptr_m = 3;
  endtask

  task automatic test_ptr_skip;
    logic [NR-1:0] rdy;
    logic [IW-1:0] id;
    logic [15:0]   res;
    req_op[3] = XOR; req_a[3] = 8'h12; req_b[3] = 8'h34;
    req_op[2] = ADD; req_a[2] = 8'd1;  req_b[2] = 8'd2;
    run_txn(4'b1000, rdy, id, res);
    total_cnt++; if (rdy !== 4'b1000 || id !== 2'd3 || res !== 16'h0026) $display("FAIL skip_g3 got rdy=%b id=%0d res=%h want 1000 3 0026", rdy, id, res); else pass_cnt++;
    run_txn(4'b0100, rdy, id, res);
    total_cnt++; if (rdy !== 4'b0100 || id !== 2'd2 || res !== 16'd3) $display("FAIL skip_g2 got rdy=%b id=%0d res=%0d want 0100 2 3", rdy, id, res); else pass_cnt++;
    // ptr should now be 3: with everyone asking, req3 wins
    run_txn(4'b1111, rdy, id, res);
    total_cnt++; if (rdy !== 4'b1000) $display("FAIL skip_ptr got rdy=%b want 1000", rdy); else pass_cnt++;
    ptr_m = 0;
  endtask

  task automatic test_reset_mid;
    req_a[1] = 8'd9; req_b[1] = 8'd9; req_op[1] = MUL;
    req_valid = 4'b0010; rsp_ready = 1'b1;
    tick();                      // accepted, now EXEC
    req_valid = '0;
    rst = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_result !== 16'h0 || req_ready !== 4'b0)
      $display("FAIL midrst got busy=%b v=%b id=%0d res=%h rdy=%b want all 0", busy, rsp_valid, rsp_id, rsp_result, req_ready); else pass_cnt++;
    tick();
    rst = 1'b0;
    ptr_m = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_quiet%0d got v=%b busy=%b want 0 0", c, rsp_valid, busy); else pass_cnt++;
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 40; it++) begin
      logic [NR-1:0] mask;
      int g, d;
      logic [15:0] exp;
      mask = NR'($urandom_range(0, 15));
      for (int r = 0; r < NR; r++) begin
        req_a[r]  = 8'($urandom_range(0, 255));
        req_b[r]  = 8'($urandom_range(0, 255));
        req_op[r] = opcode_e'($urandom_range(0, 3));
      end
      req_valid = mask; rsp_ready = 1'b0;
      g = ref_pick(mask, ptr_m);
      #1;
      if (g < 0) begin
        total_cnt++; if (req_ready !== 4'b0) $display("FAIL rnd_idle%0d got %b want 0", it, req_ready); else pass_cnt++;
        tick();
        continue;
      end
      exp = ref_alu(int'(req_a[g]), int'(req_b[g]), int'(req_op[g]));
      total_cnt++; if (req_ready !== NR'(1 << g)) $display("FAIL rnd_grant%0d got %b want %b", it, req_ready, NR'(1 << g)); else pass_cnt++;
      tick();
      req_valid = '0;
      tick();
      total_cnt++; if (rsp_valid !== 1'b1 || rsp_id !== IW'(g) || rsp_result !== exp)
        $display("FAIL rnd_rsp%0d got v=%b id=%0d res=%h want id=%0d res=%h", it, rsp_valid, rsp_id, rsp_result, g, exp); else pass_cnt++;
      d = $urandom_range(0, 3);
      for (int c = 0; c < d; c++) begin
        tick();
        total_cnt++; if (rsp_valid !== 1'b1 || rsp_result !== exp) $display("FAIL rnd_hold%0d got v=%b res=%h want 1 %h", it, rsp_valid, rsp_result, exp); else pass_cnt++;
      end
      rsp_ready = 1'b1;
      tick();
      total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rnd_done%0d got v=%b want 0", it, rsp_valid); else pass_cnt++;
      ptr_m = (g + 1) % NR;
    end
  endtask

`ifdef ALU_SCHED_STATS_EN
  task automatic test_stats;
    logic [NR-1:0] rdy;
    logic [IW-1:0] id;
    logic [15:0]   res;
    do_reset();
    for (int n = 0; n < 3; n++) run_txn(4'b0010, rdy, id, res);
    total_cnt++; if (stat_cnt[1] !== 16'd3 || stat_cnt[0] !== 16'd0 || stat_cnt[2] !== 16'd0 || stat_cnt[3] !== 16'd0)
      $display("FAIL stats_cnt got %h %h %h %h want 0 0 3 0 (3..0)", stat_cnt[3], stat_cnt[2], stat_cnt[1], stat_cnt[0]); else pass_cnt++;
    force dut.stat_cnt = {16'd0, 16'd0, 16'hFFFF, 16'd0};
    #1 release dut.stat_cnt;
    run_txn(4'b0010, rdy, id, res);
    total_cnt++; if (stat_cnt[1] !== 16'hFFFF) $display("FAIL stats_sat got %h want ffff", stat_cnt[1]); else pass_cnt++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_round_robin();
    test_backpressure();
    test_ptr_skip();
    test_reset_mid();
    test_random();
`ifdef ALU_SCHED_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
